// File: rtl/retro16_mem_pkg.sv
// Shared memory-map constants for the retro16 RAM responder: I/O page
// base, register addresses and status-word bit positions.
package retro16_mem_pkg;

  localparam logic [15:0] IO_PAGE_BASE   = 16'hFF00;
  localparam logic [15:0] IO_FIFO_ADDR   = 16'hFF00;
  localparam logic [15:0] IO_STATUS_ADDR = 16'hFF01;
  localparam logic [15:0] IO_CNT_LO_ADDR = 16'hFF02;
  localparam logic [15:0] IO_CNT_HI_ADDR = 16'hFF03;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_COUNT_LSB = 3;

  function automatic logic is_io_page(input logic [15:0] addr);
    return addr[15:8] == IO_PAGE_BASE[15:8];
  endfunction

endpackage

// File: rtl/responder_fifo.sv
// Output FIFO for the RAM responder: storage, wrapping pointers, count and
// a sticky overflow flag. A push into a full FIFO succeeds only alongside a pop.
module responder_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [15:0] push_data,
  input  logic        pop_ready,
  input  logic        clr_overflow,
  output logic [15:0] head,
  output logic        valid,
  output logic        empty,
  output logic        full,
  output logic        overflow,
  output logic [3:0]  count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [15:0]   store [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;
  logic          pop, push_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign valid   = !empty;
  assign pop     = valid && pop_ready;
  assign push_ok = push && (!full || pop);
  assign head    = empty ? 16'h0000 : store[rd_ptr_reg];
  assign count   = 4'(count_reg);
  assign overflow = overflow_reg;

  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      store[wr_ptr_reg] <= push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (push_ok && !pop)      count_reg <= count_reg + CW'(1);
      else if (pop && !push_ok) count_reg <= count_reg - CW'(1);
      if (push && !push_ok)     overflow_reg <= 1'b1;
      else if (clr_overflow)    overflow_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_responder.sv
// CPU-facing RAM with a one-cycle registered read and a memory-mapped I/O page
// (FIFO push, status, optional cycle counter via RAM_RESPONDER_CYCLE_COUNTER_EN).
module ram_responder
  import retro16_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ram_address,
  input  logic [15:0] ram_wdata,
  output logic [15:0] ram_rdata,
  input  logic        ram_read_en,
  input  logic        ram_write_en,
  output logic [15:0] io_data,
  output logic        io_valid,
  input  logic        io_ready
);

  logic [15:0] ram [2**ADDR_WIDTH];
  logic [15:0] ram_rdata_reg;
  logic [15:0] io_rd_data;
  logic        is_io, wr_acc, rd_acc;
  logic        fifo_empty, fifo_full, fifo_ovf;
  logic [3:0]  fifo_count;

  // Write wins over a simultaneous read; reset swallows both.
  assign is_io  = is_io_page(ram_address);
  assign wr_acc = ram_write_en && !rst;
  assign rd_acc = ram_read_en && !ram_write_en && !rst;

  always_ff @(posedge clk) begin
    if (wr_acc && !is_io) begin
      ram[ram_address[ADDR_WIDTH-1:0]] <= ram_wdata;
    end
  end

  responder_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (wr_acc && ram_address == IO_FIFO_ADDR),
    .push_data    (ram_wdata),
    .pop_ready    (io_ready),
    .clr_overflow (wr_acc && ram_address == IO_STATUS_ADDR && ram_wdata[STATUS_OVF_BIT]),
    .head         (io_data),
    .valid        (io_valid),
    .empty        (fifo_empty),
    .full         (fifo_full),
    .overflow     (fifo_ovf),
    .count        (fifo_count)
  );

`ifdef RAM_RESPONDER_CYCLE_COUNTER_EN
  logic [31:0] counter_reg;
  logic [15:0] shadow_reg;

  // Reading the low half freezes the high half so the pair is coherent.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_reg <= '0;
      shadow_reg  <= '0;
    end else begin
      counter_reg <= counter_reg + 32'd1;
      if (rd_acc && ram_address == IO_CNT_LO_ADDR) shadow_reg <= counter_reg[31:16];
    end
  end
`endif

  always_comb begin
    io_rd_data = 16'h0000;
    if (ram_address == IO_STATUS_ADDR) begin
      io_rd_data[STATUS_EMPTY_BIT] = fifo_empty;
      io_rd_data[STATUS_FULL_BIT]  = fifo_full;
      io_rd_data[STATUS_OVF_BIT]   = fifo_ovf;
      io_rd_data[STATUS_COUNT_LSB +: 4] = fifo_count;
    end
`ifdef RAM_RESPONDER_CYCLE_COUNTER_EN
    if (ram_address == IO_CNT_LO_ADDR) io_rd_data = counter_reg[15:0];
    if (ram_address == IO_CNT_HI_ADDR) io_rd_data = shadow_reg;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_rdata_reg <= 16'h0000;
    end else if (rd_acc) begin
      ram_rdata_reg <= is_io ? io_rd_data : ram[ram_address[ADDR_WIDTH-1:0]];
    end
  end

  assign ram_rdata = ram_rdata_reg;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: RAM read/write, collision, aliasing,
// FIFO full/overflow/pop behaviour, status register and mid-burst reset.
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ram_address, ram_wdata, ram_rdata, io_data;
  logic        ram_read_en, ram_write_en, io_valid, io_ready;

  int total = 0;
  int bad   = 0;

  ram_responder dut (
    .clk          (clk),
    .rst          (rst),
    .ram_address  (ram_address),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .ram_read_en  (ram_read_en),
    .ram_write_en (ram_write_en),
    .io_data      (io_data),
    .io_valid     (io_valid),
    .io_ready     (io_ready)
  );

  always #5 clk = ~clk;

`ifdef RAM_RESPONDER_CYCLE_COUNTER_EN
  logic [31:0] model_cnt = 32'd0;
  always @(posedge clk) model_cnt <= rst ? 32'd0 : model_cnt + 32'd1;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    ram_address = a; ram_wdata = d; ram_write_en = 1'b1;
    @(negedge clk);
    ram_write_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] q);
    ram_address = a; ram_read_en = 1'b1;
    @(negedge clk);
    ram_read_en = 1'b0;
    q = ram_rdata;
  endtask

  logic [15:0] q;
  logic [15:0] drain_exp [4] = '{16'h1002, 16'h1003, 16'h1004, 16'hAAAA};

  initial begin
    rst = 1'b1; ram_address = '0; ram_wdata = '0;
    ram_read_en = 1'b0; ram_write_en = 1'b0; io_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    check("reset_rdata", ram_rdata, 16'h0000);
    check("reset_valid", io_valid, 1'b0);
    check("reset_io_data", io_data, 16'h0000);

    wr(16'h0010, 16'h1234);
    rd(16'h0010, q);      check("wr_then_rd", q, 16'h1234);
    @(negedge clk);       check("rdata_held", ram_rdata, 16'h1234);

    // Read and write together: write lands, read is ignored.
    ram_address = 16'h0020; ram_wdata = 16'hBEEF;
    ram_read_en = 1'b1; ram_write_en = 1'b1;
    @(negedge clk);
    ram_read_en = 1'b0; ram_write_en = 1'b0;
    check("collide_rdata", ram_rdata, 16'h1234);
    rd(16'h0020, q);      check("collide_later", q, 16'hBEEF);

    wr(16'h1030, 16'h5555);
    rd(16'h0030, q);      check("alias_rd", q, 16'h5555);
    wr(16'hFEFF, 16'h6666);
    rd(16'h0EFF, q);      check("alias_top", q, 16'h6666);

    rd(16'hFF01, q);      check("status_empty", q, 16'h0001);

    for (int i = 1; i <= 5; i++) wr(16'hFF00, 16'h1000 + 16'(i));
    check("full_valid", io_valid, 1'b1);
    check("full_head", io_data, 16'h1001);
    rd(16'hFF00, q);      check("fifo_addr_rd", q, 16'h0000);
    rd(16'hFF01, q);      check("status_ovf", q, 16'h0026);
    wr(16'hFF01, 16'h0004);
    rd(16'hFF01, q);      check("status_clr", q, 16'h0022);

    // Push and pop on the same edge while full.
    ram_address = 16'hFF00; ram_wdata = 16'hAAAA; ram_write_en = 1'b1; io_ready = 1'b1;
    @(negedge clk);
    ram_write_en = 1'b0; io_ready = 1'b0;
    rd(16'hFF01, q);      check("push_pop_full", q, 16'h0022);
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", io_valid, 1'b1);
      check("drain_data", io_data, drain_exp[i]);
      io_ready = 1'b1;
      @(negedge clk);
      io_ready = 1'b0;
    end
    check("drained_valid", io_valid, 1'b0);
    check("drained_data", io_data, 16'h0000);

    wr(16'hFF00, 16'h7777);
    check("push_empty_valid", io_valid, 1'b1);
    check("push_empty_head", io_data, 16'h7777);
    wr(16'hFF00, 16'h7778);
    wr(16'hFF00, 16'h7779);
    rd(16'hFF01, q);      check("status_cnt3", q, 16'h0018);

    wr(16'hFF10, 16'h1111);
    rd(16'hFF10, q);      check("io_unused", q, 16'h0000);
`ifdef RAM_RESPONDER_CYCLE_COUNTER_EN
    begin
      logic [31:0] snap;
      snap = model_cnt;
      rd(16'hFF02, q);    check("cnt_lo", q, snap[15:0]);
      rd(16'hFF03, q);    check("cnt_hi", q, snap[31:16]);
    end
`else
    rd(16'hFF02, q);      check("cnt_lo_off", q, 16'h0000);
    rd(16'hFF03, q);      check("cnt_hi_off", q, 16'h0000);
    rd(16'hFF01, q);      check("status_cnt3_again", q, 16'h0018);
`endif

    // Reset with a concurrent RAM write, which must be ignored.
    ram_address = 16'h0010; ram_wdata = 16'hDEAD; ram_write_en = 1'b1; rst = 1'b1;
    @(negedge clk);
    ram_write_en = 1'b0; rst = 1'b0;
    check("rst_valid", io_valid, 1'b0);
    check("rst_rdata", ram_rdata, 16'h0000);
    check("rst_io_data", io_data, 16'h0000);
    rd(16'hFF01, q);      check("rst_status", q, 16'h0001);
    rd(16'h0010, q);      check("rst_ram_kept", q, 16'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
